// File: rtl/fir_tap_axil_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_tap_axil_pkg
//  Description : Shared constants for the FIR tap AXI4-Lite slave: register
//                address map, ap_ctrl bit positions and FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package fir_tap_axil_pkg;

    // Register map (byte addresses)
    localparam logic [31:0] c_addr_ap_ctrl  = 32'h0000_0000;
    localparam logic [31:0] c_addr_data_len = 32'h0000_0010;
    localparam logic [31:0] c_addr_tap_base = 32'h0000_0040;

    // ap_ctrl bit positions
    localparam int c_bit_ap_start = 0;
    localparam int c_bit_ap_done  = 1;
    localparam int c_bit_ap_idle  = 2;

    // AXI FSM state encoding
    localparam int                  c_state_w     = 2;
    localparam logic [c_state_w-1:0] c_st_idle    = 2'd0;
    localparam logic [c_state_w-1:0] c_st_wr_resp = 2'd1;
    localparam logic [c_state_w-1:0] c_st_rd_bram = 2'd2;
    localparam logic [c_state_w-1:0] c_st_rd_resp = 2'd3;

endpackage
`default_nettype wire

// File: rtl/fir_ctrl_regs.sv
`default_nettype none
// ============================================================================
//  Module      : fir_ctrl_regs
//  Description : ap_ctrl / data_length configuration registers with the
//                engine start/done/idle handshake.
//  Ports       : clk, rst_n        - clock, asynchronous active-low reset
//                i_wr_en/addr/data - register write strobe from the AXI side
//                i_rd_clr_done     - ap_ctrl read in progress (clears ap_done)
//                i_eng_done        - engine finished pulse
//                o_ap_start/done/idle, o_data_length - register state
//  Revision    : 1.0  initial release
// ============================================================================
module fir_ctrl_regs
    import fir_tap_axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_clr_done,
    input  logic                  i_eng_done,
    output logic                  o_ap_start,
    output logic                  o_ap_done,
    output logic                  o_ap_idle,
    output logic [DATA_WIDTH-1:0] o_data_length
);

    logic                  r_ap_start;
    logic                  r_ap_done;
    logic                  r_ap_idle;
    logic [DATA_WIDTH-1:0] r_data_length;

    logic w_ctrl_hit;
    logic w_len_hit;

    assign w_ctrl_hit = i_wr_en && (i_wr_addr == ADDR_WIDTH'(c_addr_ap_ctrl));
    assign w_len_hit  = i_wr_en && (i_wr_addr == ADDR_WIDTH'(c_addr_data_len));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ap_start    <= 1'b0;
            r_ap_done     <= 1'b0;
            r_ap_idle     <= 1'b1;
            r_data_length <= '0;
        end else begin
            r_ap_start <= 1'b0;
            // Configuration is frozen while the engine runs.
            if (w_ctrl_hit && i_wr_data[c_bit_ap_start] && r_ap_idle) begin
                r_ap_start <= 1'b1;
                r_ap_idle  <= 1'b0;
                r_ap_done  <= 1'b0;
            end
            if (w_len_hit && r_ap_idle) begin
                r_data_length <= i_wr_data;
            end
            if (i_rd_clr_done) begin
                r_ap_done <= 1'b0;
            end
            // Placed last so a coincident done pulse beats the read-clear.
            if (i_eng_done) begin
                r_ap_done <= 1'b1;
                r_ap_idle <= 1'b1;
            end
        end
    end

    assign o_ap_start    = r_ap_start;
    assign o_ap_done     = r_ap_done;
    assign o_ap_idle     = r_ap_idle;
    assign o_data_length = r_data_length;

endmodule
`default_nettype wire

// File: rtl/fir_tap_axil.sv
`default_nettype none
// ============================================================================
//  Module      : fir_tap_axil
//  Description : AXI4-Lite slave in front of the FIR tap coefficient BRAM.
//                Maps host accesses onto the BRAM byte-enabled write port and
//                registered-address read port, holds ap_ctrl/data_length, and
//                hands the BRAM address to the engine while it is busy.
//  Ports       : axis_clk, axis_rst_n        - clock, async active-low reset
//                aw*/w*/b*/ar*/r*            - AXI4-Lite slave
//                tap_WE/EN/Di/A, tap_Do      - tap BRAM port
//                eng_tap_A, eng_done         - engine side
//                ap_start, data_length       - engine configuration
//  Revision    : 1.0  initial release
// ============================================================================
module fir_tap_axil
    import fir_tap_axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int TAP_NUM    = 11
) (
    input  logic                  axis_clk,
    input  logic                  axis_rst_n,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wvalid,
    output logic                  wready,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [3:0]            tap_WE,
    output logic                  tap_EN,
    output logic [DATA_WIDTH-1:0] tap_Di,
    output logic [ADDR_WIDTH-1:0] tap_A,
    input  logic [DATA_WIDTH-1:0] tap_Do,
    input  logic [ADDR_WIDTH-1:0] eng_tap_A,
    input  logic                  eng_done,
    output logic                  ap_start,
    output logic [DATA_WIDTH-1:0] data_length
);

    localparam logic [ADDR_WIDTH-1:0] c_tap_base = ADDR_WIDTH'(c_addr_tap_base);
    localparam logic [ADDR_WIDTH-1:0] c_tap_end  = ADDR_WIDTH'(c_addr_tap_base + 32'(4 * TAP_NUM));

    function automatic logic f_is_tap(input logic [ADDR_WIDTH-1:0] a);
        return (a >= c_tap_base) && (a < c_tap_end);
    endfunction

    logic [c_state_w-1:0]  r_state;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_rd_tap_ok;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_wr_fire;
    logic                  w_rd_fire;
    logic                  w_rd_clr_done;
    logic                  w_ap_done;
    logic                  w_ap_idle;
    logic [DATA_WIDTH-1:0] w_ctrl_word;

    // Handshakes are decoded from the state so they fall the instant reset
    // is asserted; a complete write pair outranks a pending read.
    assign w_wr_fire = axis_rst_n && (r_state == c_st_idle) && awvalid && wvalid;
    assign w_rd_fire = axis_rst_n && (r_state == c_st_idle) && arvalid && !(awvalid && wvalid);

    assign awready = w_wr_fire;
    assign wready  = w_wr_fire;
    assign arready = w_rd_fire;
    assign bvalid  = (r_state == c_st_wr_resp);
    assign rvalid  = (r_state == c_st_rd_resp);
    assign rdata   = r_rdata;

    // ap_done is cleared by the same cycle that samples it into rdata.
    assign w_rd_clr_done = (r_state == c_st_rd_bram) && (r_rd_addr == ADDR_WIDTH'(c_addr_ap_ctrl));

    fir_ctrl_regs #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ctrl_regs (
        .clk           (axis_clk),
        .rst_n         (axis_rst_n),
        .i_wr_en       (w_wr_fire),
        .i_wr_addr     (awaddr),
        .i_wr_data     (wdata),
        .i_rd_clr_done (w_rd_clr_done),
        .i_eng_done    (eng_done),
        .o_ap_start    (ap_start),
        .o_ap_done     (w_ap_done),
        .o_ap_idle     (w_ap_idle),
        .o_data_length (data_length)
    );

    always_comb begin
        w_ctrl_word                 = '0;
        w_ctrl_word[c_bit_ap_start] = ap_start;
        w_ctrl_word[c_bit_ap_done]  = w_ap_done;
        w_ctrl_word[c_bit_ap_idle]  = w_ap_idle;
    end

    // BRAM port mux: the engine owns the address port whenever it is busy.
    always_comb begin
        tap_WE = 4'h0;
        tap_EN = 1'b0;
        tap_A  = '0;
        tap_Di = '0;
        if (!w_ap_idle) begin
            tap_A  = eng_tap_A;
            tap_EN = 1'b1;
        end else if (w_wr_fire && f_is_tap(awaddr)) begin
            tap_A  = awaddr - c_tap_base;
            tap_EN = 1'b1;
            tap_WE = 4'hF;
            tap_Di = wdata;
        end else if (w_rd_fire) begin
            tap_A  = araddr - c_tap_base;
            tap_EN = 1'b1;
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_state     <= c_st_idle;
            r_rd_addr   <= '0;
            r_rd_tap_ok <= 1'b0;
            r_rdata     <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_wr_fire) begin
                        r_state <= c_st_wr_resp;
                    end else if (w_rd_fire) begin
                        r_state     <= c_st_rd_bram;
                        r_rd_addr   <= araddr;
                        // Only trust tap_Do if the host owned the BRAM port.
                        r_rd_tap_ok <= f_is_tap(araddr) && w_ap_idle;
                    end
                end
                c_st_rd_bram: begin
                    if (r_rd_tap_ok) begin
                        r_rdata <= tap_Do;
                    end else if (r_rd_addr == ADDR_WIDTH'(c_addr_ap_ctrl)) begin
                        r_rdata <= w_ctrl_word;
                    end else if (r_rd_addr == ADDR_WIDTH'(c_addr_data_len)) begin
                        r_rdata <= data_length;
                    end else begin
                        r_rdata <= '0;
                    end
                    r_state <= c_st_rd_resp;
                end
                c_st_rd_resp: begin
                    if (rready) begin
                        r_state <= c_st_idle;
                    end
                end
                c_st_wr_resp: begin
                    if (bready) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire
